seq_alu: RTL and testbench

// - Parametrised, registered ALU for the processor datapath; successor to the 8-bit combinational ALU.
// - Single-cycle ops: add, sub, mul, shifts and squares. Divide is iterative (restoring, one bit/cycle).
// - valid/ready handshake on both sides; result, high word, flags and error held until consumed.

---
 rtl/seq_alu.sv | 249 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
// Single-cycle add/sub/mul/shift/square ops. Divide is a restoring divider
// that produces one quotient bit per cycle.
// Optional build macro: SEQ_ALU_SAT_EN makes ADD saturate to all-ones on
// carry and SUB saturate to zero on borrow. carry_out still reports the raw
// carry or borrow.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             zero,
    output logic             err
);

    // Divider iteration counter width, derived from WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_SQA = 4'b0110;
    localparam logic [3:0] OP_SQB = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Output registers: held stable while in DONE.
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             err_reg;

    // Divider working registers.
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Combinational results for the op being accepted.
    logic [WIDTH-1:0]   op_res;
    logic [WIDTH-1:0]   op_hi;
    logic               op_carry;
    logic               op_err;
    logic               op_zero;
    logic               op_is_div;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   mul_x;
    logic [WIDTH-1:0]   mul_y;
    logic [2*WIDTH-1:0] prod;

    // One restoring-division step.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;

    logic accept;
    logic div_last;

    assign accept   = in_valid && in_ready;
    assign div_last = (cnt_reg == DIV_LAST);

    // Shared adder/subtractor and one multiplier.
    // The multiplier operands are muxed so MUL, SQA and SQB use the same unit.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        mul_x = (alu_sel == OP_SQB) ? b : a;
        mul_y = (alu_sel == OP_SQA) ? a : b;
        prod  = {{WIDTH{1'b0}}, mul_x} * {{WIDTH{1'b0}}, mul_y};
    end

    // Decode the presented op into its result, high word and flags.
    always_comb begin
        op_res    = '0;
        op_hi     = '0;
        op_carry  = 1'b0;
        op_err    = 1'b0;
        op_is_div = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                op_res   = sum[WIDTH-1:0];
                op_carry = sum[WIDTH];
`ifdef SEQ_ALU_SAT_EN
                if (sum[WIDTH]) begin
                    op_res = '1;
                end
`endif
            end
            OP_SUB: begin
                op_res   = diff[WIDTH-1:0];
                op_carry = diff[WIDTH];
`ifdef SEQ_ALU_SAT_EN
                if (diff[WIDTH]) begin
                    op_res = '0;
                end
`endif
            end
            OP_MUL, OP_SQA, OP_SQB: begin
                op_res   = prod[WIDTH-1:0];
                op_hi    = prod[2*WIDTH-1:WIDTH];
                op_carry = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (b == '0) begin
                    // Divide by zero finishes at once, with no DIV state.
                    op_res = '1;
                    op_hi  = a;
                    op_err = 1'b1;
                end else begin
                    op_is_div = 1'b1;
                end
            end
            OP_SHL: begin
                op_res   = {a[WIDTH-2:0], 1'b0};
                op_carry = a[WIDTH-1];
            end
            OP_SHR: begin
                op_res   = {1'b0, a[WIDTH-1:1]};
                op_carry = a[0];
            end
            default: begin
                op_err = 1'b1;
            end
        endcase
        op_zero = (op_res == '0);
    end

    // Restoring division: shift in the next dividend bit, then subtract if it fits.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor_reg};
        if (!trial[WIDTH]) begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = rem_shift[WIDTH-1:0];
            step_quo = {quo_reg[WIDTH-2:0], 1'b0};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = op_is_div ? S_DIV : S_DONE;
                end
            end
            S_DIV: begin
                if (div_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE, present the result only in DONE.
    always_comb begin
        in_ready  = (state_reg == S_IDLE);
        out_valid = (state_reg == S_DONE);
    end

    // Datapath: capture operands or results at accept, run the divider in DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            result_hi_reg <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            err_reg       <= 1'b0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            cnt_reg       <= '0;
        end else if (accept) begin
            if (op_is_div) begin
                quo_reg     <= a;
                rem_reg     <= '0;
                divisor_reg <= b;
                cnt_reg     <= '0;
            end else begin
                result_reg    <= op_res;
                result_hi_reg <= op_hi;
                carry_reg     <= op_carry;
                zero_reg      <= op_zero;
                err_reg       <= op_err;
            end
        end else if (state_reg == S_DIV) begin
            quo_reg <= step_quo;
            rem_reg <= step_rem;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (div_last) begin
                result_reg    <= step_quo;
                result_hi_reg <= step_rem;
                carry_reg     <= 1'b0;
                zero_reg      <= (step_quo == '0);
                err_reg       <= 1'b0;
            end
        end
    end

    assign result    = result_reg;
    assign result_hi = result_hi_reg;
    assign carry_out = carry_reg;
    assign zero      = zero_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
// The 8-bit instance covers all ops. A 16-bit instance covers the wide divide.
// It also checks the SEQ_ALU_SAT_EN build when that macro is defined.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit instance
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, result, result_hi;
    logic [3:0] alu_sel;
    logic       carry_out, zero, err;

    // 16-bit instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, result16, result_hi16;
    logic [3:0]  alu_sel16;
    logic        carry_out16, zero16, err16;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .carry_out(carry_out), .zero(zero), .err(err)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .alu_sel(alu_sel16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .result_hi(result_hi16),
        .carry_out(carry_out16), .zero(zero16), .err(err16)
    );

`ifdef SEQ_ALU_SAT_EN
    localparam int ADD_EXP = 255;
    localparam int SUB_EXP = 0;
    localparam int SUB_ZERO = 1;
`else
    localparam int ADD_EXP = 44;
    localparam int SUB_EXP = 254;
    localparam int SUB_ZERO = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one op and wait for out_valid. Checks latency, and for multi-cycle ops
    // checks that in_ready stays low. Operands are scrambled right after accept.
    task automatic issue8(input logic [3:0] sel, input logic [7:0] av, input logic [7:0] bv,
                          input int exp_lat, input string tag);
        int   n;
        logic busy_ok;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        alu_sel  = sel;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'hA5;
        b        = 8'h3C;
        alu_sel  = 4'h2;
        n        = 1;
        busy_ok  = 1'b1;
        while (!out_valid && n < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        if (exp_lat > 1) check({tag, ".busy"}, 32'(busy_ok), 32'd1);
        $display("op %s sel=%b a=%0d b=%0d -> result=%0d hi=%0d c=%0b z=%0b e=%0b lat=%0d",
                 tag, sel, av, bv, result, result_hi, carry_out, zero, err, n);
    endtask

    task automatic expect8(input string tag, input logic [7:0] r, input logic [7:0] h,
                           input logic c, input logic z, input logic e);
        check({tag, ".result"},    32'(result),    32'(r));
        check({tag, ".result_hi"}, 32'(result_hi), 32'(h));
        check({tag, ".carry"},     32'(carry_out), 32'(c));
        check({tag, ".zero"},      32'(zero),      32'(z));
        check({tag, ".err"},       32'(err),       32'(e));
    endtask

    task automatic consume8(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".drop"}, 32'(out_valid), 32'd0);
        check({tag, ".idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int   n;
        logic quiet;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_sel = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; alu_sel16 = '0;

        #12;
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result",    32'(result),    32'd0);
        check("reset.result_hi", 32'(result_hi), 32'd0);
        check("reset.flags",     32'({carry_out, zero, err}), 32'd0);
        $display("reset applied: in_ready=%0b out_valid=%0b", in_ready, out_valid);
        @(negedge clk);
        rst_n = 1'b1;

        issue8(4'b0000, 8'd200, 8'd100, 1, "add");
        expect8("add", 8'(ADD_EXP), 8'd0, 1'b1, 1'b0, 1'b0);
        consume8("add");

        issue8(4'b0001, 8'd10, 8'd3, 1, "sub_pos");
        expect8("sub_pos", 8'd7, 8'd0, 1'b0, 1'b0, 1'b0);
        consume8("sub_pos");

        issue8(4'b0010, 8'd20, 8'd15, 1, "mul");
        expect8("mul", 8'h2C, 8'h01, 1'b1, 1'b0, 1'b0);
        consume8("mul");

        issue8(4'b0111, 8'd3, 8'd16, 1, "sqb");
        expect8("sqb", 8'd0, 8'd1, 1'b1, 1'b1, 1'b0);
        consume8("sqb");

        issue8(4'b0110, 8'd12, 8'd99, 1, "sqa");
        expect8("sqa", 8'd144, 8'd0, 1'b0, 1'b0, 1'b0);
        consume8("sqa");

        issue8(4'b0100, 8'h81, 8'd0, 1, "shl");
        expect8("shl", 8'h02, 8'd0, 1'b1, 1'b0, 1'b0);
        consume8("shl");

        issue8(4'b0101, 8'h81, 8'd0, 1, "shr");
        expect8("shr", 8'h40, 8'd0, 1'b1, 1'b0, 1'b0);
        consume8("shr");

        issue8(4'b0011, 8'd200, 8'd7, 9, "div");
        expect8("div", 8'd28, 8'd4, 1'b0, 1'b0, 1'b0);
        consume8("div");

        issue8(4'b0011, 8'd5, 8'd0, 1, "div0");
        expect8("div0", 8'd255, 8'd5, 1'b0, 1'b0, 1'b1);
        consume8("div0");

        issue8(4'b1010, 8'd9, 8'd9, 1, "illegal");
        expect8("illegal", 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
        consume8("illegal");

        // Backpressure: the result holds and new ops are ignored while out_ready is low.
        issue8(4'b0001, 8'd3, 8'd5, 1, "sub_bp");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'd1; b = 8'd1; alu_sel = 4'b0000;
            @(posedge clk);
            #1;
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready",  32'(in_ready),  32'd0);
            check("bp.result",    32'(result),    32'(SUB_EXP));
            check("bp.carry",     32'(carry_out), 32'd1);
            check("bp.zero",      32'(zero),      32'(SUB_ZERO));
            $display("hold cycle %0d: result=%0d carry=%0b in_ready=%0b", i, result, carry_out, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume8("sub_bp");

        // Reset in the middle of a divide aborts it; nothing is emitted afterwards.
        @(negedge clk);
        alu_sel = 4'b0011; a = 8'd200; b = 8'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_div.out_valid", 32'(out_valid), 32'd0);
        check("rst_div.in_ready",  32'(in_ready),  32'd1);
        check("rst_div.result",    32'(result),    32'd0);
        check("rst_div.result_hi", 32'(result_hi), 32'd0);
        check("rst_div.flags",     32'({carry_out, zero, err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) quiet = 1'b0;
        end
        check("rst_div.no_emit", 32'(quiet), 32'd1);
        $display("reset mid-divide: out_valid seen after release=%0b", !quiet);

        // 16-bit divide: 60000 / 7 gives 8571 remainder 3, after 17 cycles.
        @(negedge clk);
        check("div16.in_ready", 32'(in_ready16), 32'd1);
        alu_sel16 = 4'b0011; a16 = 16'd60000; b16 = 16'd7; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0; a16 = 16'h1234; b16 = 16'd3;
        n = 1;
        while (!out_valid16 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("div16.latency",   32'(n),           32'd17);
        check("div16.result",    32'(result16),    32'd8571);
        check("div16.result_hi", 32'(result_hi16), 32'd3);
        check("div16.err",       32'(err16),       32'd0);
        $display("op div16 a=60000 b=7 -> result=%0d hi=%0d lat=%0d", result16, result_hi16, n);
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        out_ready16 = 1'b0;
        check("div16.drop", 32'(out_valid16), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
